// File: rtl/hex_entry_pkg.sv
// Shared types and constants for the hex word-entry controller.
package hex_entry_pkg;

    typedef enum logic {
        EDIT = 1'b0,
        SEND = 1'b1
    } state_e;

    // Active-low digit anodes, same encoding as the display driver.
    localparam logic [7:0] A0 = 8'b1111_1110;
    localparam logic [7:0] A1 = 8'b1111_1101;
    localparam logic [7:0] A2 = 8'b1111_1011;
    localparam logic [7:0] A3 = 8'b1111_0111;
    localparam logic [7:0] A4 = 8'b1110_1111;
    localparam logic [7:0] A5 = 8'b1101_1111;
    localparam logic [7:0] A6 = 8'b1011_1111;
    localparam logic [7:0] A7 = 8'b0111_1111;

    function automatic int db_cnt_w(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hex_entry_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter,
// debounced level and a one-cycle pulse on each debounced press.
module btn_debounce
    import hex_entry_pkg::*;
#(
    parameter int DB_CYCLES = 1000
) (
    input  logic clk,
    input  logic Rst,
    input  logic btn,
    output logic pulse
);

    localparam int CW = db_cnt_w(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    // Level flips only after DB_CYCLES consecutive differing samples.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            level_d = sync_q[1];
            pulse_d = sync_q[1];
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/hex_entry.sv
// Hex word-entry controller: builds a 32-bit word digit by digit from
// debounced buttons and a switch nibble, then offers it over valid/ready.
module hex_entry
    import hex_entry_pkg::*;
#(
    parameter int DB_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic [3:0]  sw,
    input  logic        btn_load,
    input  logic        btn_back,
    input  logic        btn_send,
    input  logic        btn_clr,
    output logic [31:0] word,
    output logic [2:0]  cursor,
    output logic [7:0]  cursor_an,
    output logic        valid,
    input  logic        ready
);

    logic load_p, back_p, send_p, clr_p;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_load (
        .clk(clk), .Rst(Rst), .btn(btn_load), .pulse(load_p)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_back (
        .clk(clk), .Rst(Rst), .btn(btn_back), .pulse(back_p)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_send (
        .clk(clk), .Rst(Rst), .btn(btn_send), .pulse(send_p)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clk(clk), .Rst(Rst), .btn(btn_clr), .pulse(clr_p)
    );

    logic [3:0]  sw_q1, sw_q2;
    state_e      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [2:0]  cursor_q, cursor_d;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            sw_q1    <= '0;
            sw_q2    <= '0;
            state_q  <= EDIT;
            word_q   <= '0;
            cursor_q <= '0;
        end else begin
            sw_q1    <= sw;
            sw_q2    <= sw_q1;
            state_q  <= state_d;
            word_q   <= word_d;
            cursor_q <= cursor_d;
        end
    end

    // Only the highest-priority pulse acts; SEND drops every pulse.
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        cursor_d = cursor_q;
        unique case (state_q)
            EDIT: begin
                if (clr_p) begin
                    word_d   = '0;
                    cursor_d = '0;
                end else if (send_p) begin
                    state_d = SEND;
                end else if (load_p) begin
                    word_d[{cursor_q, 2'b00} +: 4] = sw_q2;
                    cursor_d = cursor_q + 3'd1;
                end else if (back_p) begin
                    cursor_d = cursor_q - 3'd1;
                end
            end
            SEND: begin
                if (ready) begin
                    state_d  = EDIT;
                    cursor_d = '0;
                end
            end
        endcase
    end

    always_comb begin
        cursor_an = A0;
        unique case (cursor_q)
            3'd0: cursor_an = A0;
            3'd1: cursor_an = A1;
            3'd2: cursor_an = A2;
            3'd3: cursor_an = A3;
            3'd4: cursor_an = A4;
            3'd5: cursor_an = A5;
            3'd6: cursor_an = A6;
            3'd7: cursor_an = A7;
        endcase
    end

    assign word   = word_q;
    assign cursor = cursor_q;
    assign valid  = (state_q == SEND);

endmodule

// File: tb/tb_hex_entry.sv
// Directed self-checking bench for hex_entry with DB_CYCLES=4.
module tb_hex_entry;

    logic        clk = 1'b0;
    logic        Rst = 1'b1;
    logic [3:0]  sw = 4'h0;
    logic        btn_load = 1'b0;
    logic        btn_back = 1'b0;
    logic        btn_send = 1'b0;
    logic        btn_clr = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] word;
    logic [2:0]  cursor;
    logic [7:0]  cursor_an;
    logic        valid;

    int total = 0;
    int bad = 0;

    hex_entry #(.DB_CYCLES(4)) dut (
        .clk(clk), .Rst(Rst), .sw(sw),
        .btn_load(btn_load), .btn_back(btn_back),
        .btn_send(btn_send), .btn_clr(btn_clr),
        .word(word), .cursor(cursor), .cursor_an(cursor_an),
        .valid(valid), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // 0=load 1=back 2=send 3=clr; hold long enough to debounce both edges
    task automatic press(input int which);
        @(negedge clk);
        case (which)
            0: btn_load = 1'b1;
            1: btn_back = 1'b1;
            2: btn_send = 1'b1;
            default: btn_clr = 1'b1;
        endcase
        cyc(10);
        btn_load = 1'b0;
        btn_back = 1'b0;
        btn_send = 1'b0;
        btn_clr  = 1'b0;
        cyc(10);
    endtask

    initial begin
        cyc(3);
        chk("rst_word", word, 32'h0);
        chk("rst_cursor", {29'd0, cursor}, 32'd0);
        chk("rst_an", {24'd0, cursor_an}, 32'hFE);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        Rst = 1'b0;
        cyc(2);

        // Entry of digits 1..8
        for (int i = 1; i <= 8; i++) begin
            sw = 4'(i);
            press(0);
        end
        chk("entry_word", word, 32'h87654321);
        chk("entry_cursor", {29'd0, cursor}, 32'd0);
        chk("entry_an", {24'd0, cursor_an}, 32'hFE);

        // Back wraps 0 -> 7
        press(1);
        chk("back_cursor", {29'd0, cursor}, 32'd7);
        chk("back_an", {24'd0, cursor_an}, 32'h7F);
        chk("back_word", word, 32'h87654321);
        sw = 4'hF;
        press(0);
        chk("wrap_word", word, 32'hF7654321);
        chk("wrap_cursor", {29'd0, cursor}, 32'd0);

        // 3-cycle glitch: no load
        sw = 4'hA;
        cyc(2);
        btn_load = 1'b1;
        cyc(3);
        btn_load = 1'b0;
        cyc(15);
        chk("glitch_word", word, 32'hF7654321);
        chk("glitch_cursor", {29'd0, cursor}, 32'd0);

        // Bounce on2/off1/on10: one load
        btn_load = 1'b1;
        cyc(2);
        btn_load = 1'b0;
        cyc(1);
        btn_load = 1'b1;
        cyc(10);
        btn_load = 1'b0;
        cyc(15);
        chk("bounce_word", word, 32'hF765432A);
        chk("bounce_cursor", {29'd0, cursor}, 32'd1);

        // Send with ready low, presses ignored
        ready = 1'b0;
        press(2);
        chk("send_valid", {31'd0, valid}, 32'd1);
        sw = 4'h3;
        press(0);
        press(3);
        chk("hold_valid", {31'd0, valid}, 32'd1);
        chk("hold_word", word, 32'hF765432A);
        chk("hold_cursor", {29'd0, cursor}, 32'd1);
        ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hs_valid", {31'd0, valid}, 32'd0);
        chk("hs_word", word, 32'hF765432A);
        chk("hs_cursor", {29'd0, cursor}, 32'd0);
        @(negedge clk);
        ready = 1'b0;
        cyc(2);

        // clr + load together: clr wins
        sw = 4'h9;
        btn_clr = 1'b1;
        btn_load = 1'b1;
        cyc(10);
        btn_clr = 1'b0;
        btn_load = 1'b0;
        cyc(10);
        chk("sim_clr_word", word, 32'h0);
        chk("sim_clr_cursor", {29'd0, cursor}, 32'd0);
        sw = 4'h5;
        press(0);
        chk("load5_word", word, 32'h5);

        // send + load together: send wins
        btn_send = 1'b1;
        btn_load = 1'b1;
        cyc(10);
        btn_send = 1'b0;
        btn_load = 1'b0;
        cyc(10);
        chk("sim_send_valid", {31'd0, valid}, 32'd1);
        chk("sim_send_word", word, 32'h5);
        chk("sim_send_cursor", {29'd0, cursor}, 32'd1);

        // Reset in SEND, mid-debounce, button held through release
        sw = 4'h3;
        btn_load = 1'b1;
        cyc(3);
        Rst = 1'b1;
        #1;
        chk("mid_rst_word", word, 32'h0);
        chk("mid_rst_valid", {31'd0, valid}, 32'd0);
        chk("mid_rst_an", {24'd0, cursor_an}, 32'hFE);
        cyc(2);
        Rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("held_e6_cursor", {29'd0, cursor}, 32'd0);
        @(posedge clk);
        #1;
        chk("held_e7_cursor", {29'd0, cursor}, 32'd1);
        chk("held_e7_word", word, 32'h3);
        cyc(20);
        chk("held_once", {29'd0, cursor}, 32'd1);
        btn_load = 1'b0;
        cyc(15);
        chk("release_nopulse", {29'd0, cursor}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
